exu_operand_stage: RTL
======================

Name: exu_operand_stage

Overview:
- Registered ID→EX boundary stage that sits directly upstream of the execute-stage ALU.
- Accepts decoded micro-ops over a valid/ready handshake and resolves the src1/src2 operand muxes, including RV64 word-op operand conditioning.
- Presents stable ALU operands and ALU controls to the combinational ALU.
- Contains a 2-entry skid buffer, so in_ready is a pure register output and the stage sustains one op per cycle under backpressure.

Parameters:
- XLEN, 64, datapath width of operands, pc and immediate.
- CNT_W, 32, width of the stall counter (used only with the optional feature).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous kill of all buffered ops (branch redirect/trap).
- in_valid, input, 1, upstream op valid.
- in_ready, output, 1, stage can accept an op this cycle.
- in_pc, input, XLEN, pc of the op.
- in_rs1_data, input, XLEN, rs1 read value.
- in_rs2_data, input, XLEN, rs2 read value.
- in_imm, input, XLEN, sign-extended immediate.
- in_src1_sel, input, 2, 0=rs1, 1=pc, 2/3=zero.
- in_src2_sel, input, 2, 0=rs2, 1=imm, 2=constant 4, 3=zero.
- in_func_control, input, 4, ALU unit select (0 adder, 1 shift, 2 compare, 3 div, 4 logic, 5 mul, 6 lui).
- in_inner_control, input, 4, unit sub-op; for div, bit1=1 means unsigned.
- in_word_op, input, 1, RV64 *W instruction.
- in_rd, input, 5, destination register.
- in_rd_wen, input, 1, destination write enable.
- out_valid, output, 1, operands valid to the ALU/EX.
- out_ready, input, 1, downstream accepts this cycle.
- out_src1, output, XLEN, ALU src1.
- out_src2, output, XLEN, ALU src2.
- out_func_control, output, 4, registered func_control.
- out_inner_control, output, 4, registered inner_control.
- out_word_op, output, 1, registered word_op (downstream sign-extends result[31:0]).
- out_pc, output, XLEN, registered pc.
- out_rd, output, 5, registered rd.
- out_rd_wen, output, 1, registered rd_wen.

Behaviour:
- Reset (rst_n low, asynchronous):
  - main_valid=0, skid_valid=0.
  - Every output data/control field is 0; out_valid=0; in_ready=1.
- Operand resolution is combinational on the input side; resolved values are captured into the entry, so outputs are pure flops.
- Word-op conditioning (applied before capture):
  - func=1 (shift) with word_op: src2 = {59'b0, src2[4:0]}.
  - func=3 (div) with word_op: src1 and src2 extended from bit 31, zero-extended if inner_control[1]=1, else sign-extended.
  - All other funcs: operands pass unmodified.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Ready/valid: in_ready = !skid_valid (registered). out_valid = main_valid.
- Entry updates per cycle, by priority:
  - flush: main_valid←0 and skid_valid←0; in_valid that cycle is dropped; payload regs may hold stale data.
  - !main_valid & in_fire: main←in.
  - main_valid & out_fire & in_fire: main←skid if skid_valid, else main←in; if skid_valid, skid←in.
  - main_valid & out_fire & !in_fire: main←skid and main_valid←skid_valid; skid_valid←0.
  - main_valid & !out_fire & in_fire: skid←in, skid_valid←1 (in_ready falls next cycle).
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput: 1 op/cycle while out_ready=1.
- Ordering: strictly FIFO, no op duplicated or lost except under flush.
- Full (skid_valid=1): in_ready=0; in_valid held by upstream is not taken.
- Payload stability: out_* payload changes only on out_fire or on a load into an empty main.

Optional Feature:
- Macro: EXU_OPERAND_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [CNT_W-1:0]; increments each cycle out_valid & !out_ready.
  - Saturates at all-ones; cleared by rst_n only (not by flush).
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: two ops buffered, pulse rst_n low → out_valid=0 and in_ready=1 immediately (async); outputs all 0.
- ADDI word op: rs1=0xFFFFFFFF_80000000, imm=5, src2_sel=1, func=0, word_op=1 → out_src1=0xFFFFFFFF_80000000, out_src2=5 one cycle later.
- DIVUW: rs1=0xDEAD_0000_FFFF_FFFE, rs2=0x1_0000_0002, func=3, inner=4'b0010, word_op=1 → src1=0x00000000_FFFFFFFE, src2=0x2. Same op with inner=0 → src1=0xFFFFFFFF_FFFFFFFE.
- JAL link: src1_sel=1, src2_sel=2, pc=0x8000_0010 → out_src1=0x8000_0010, out_src2=4.
- Backpressure: stream ops A,B,C with out_ready=0 → A in main, B in skid, in_ready=0, C held. Raise out_ready → A, B, C delivered in order over 3 cycles, none lost. With the macro defined, stall_cnt equals the number of stalled cycles.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1; the in-flight op is not captured.

Source files
------------

// File: rtl/exu_operand_stage.sv
// ID->EX operand stage: resolves ALU operands (with RV64 word-op conditioning) into a 2-entry skid buffer.
// Optional EXU_OPERAND_STALL_CNT_EN adds a saturating stall_cnt output counting out_valid & !out_ready cycles.
module exu_operand_stage #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [1:0]        in_src1_sel,
   input  logic [1:0]        in_src2_sel,
   input  logic [3:0]        in_func_control,
   input  logic [3:0]        in_inner_control,
   input  logic              in_word_op,
   input  logic [4:0]        in_rd,
   input  logic              in_rd_wen,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_src1,
   output logic [XLEN-1:0]   out_src2,
   output logic [3:0]        out_func_control,
   output logic [3:0]        out_inner_control,
   output logic              out_word_op,
   output logic [XLEN-1:0]   out_pc,
   output logic [4:0]        out_rd,
   output logic              out_rd_wen
`ifdef EXU_OPERAND_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned SHAMT_W     = 5;
   localparam logic [3:0]  FUNC_SHIFT  = 4'd1;
   localparam logic [3:0]  FUNC_DIV    = 4'd3;

   if (XLEN <= WORD_W) begin : g_bad_xlen
      $error("XLEN must exceed 32");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   typedef struct packed {
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
      logic [XLEN-1:0] pc;
      logic [3:0]      func_control;
      logic [3:0]      inner_control;
      logic            word_op;
      logic [4:0]      rd;
      logic            rd_wen;
   } entry_t;

   entry_t     in_entry_c;
   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   logic       main_valid, main_valid_d;
   logic       skid_valid, skid_valid_d;
   logic [XLEN-1:0] src1_c, src2_c;
   logic       in_fire_c, out_fire_c;

   assign in_fire_c  = in_valid & in_ready;
   assign out_fire_c = main_valid & out_ready;

   // Operand muxes plus word-op conditioning, resolved before capture.
   always_comb begin
      src1_c = '0;
      src2_c = '0;
      case (in_src1_sel)
         2'd0:    src1_c = in_rs1_data;
         2'd1:    src1_c = in_pc;
         default: src1_c = '0;
      endcase
      case (in_src2_sel)
         2'd0:    src2_c = in_rs2_data;
         2'd1:    src2_c = in_imm;
         2'd2:    src2_c = XLEN'(4);
         default: src2_c = '0;
      endcase
      if (in_word_op && (in_func_control == FUNC_SHIFT)) begin
         src2_c = XLEN'(src2_c[SHAMT_W-1:0]);
      end else if (in_word_op && (in_func_control == FUNC_DIV)) begin
         if (in_inner_control[1]) begin
            src1_c = XLEN'(src1_c[WORD_W-1:0]);
            src2_c = XLEN'(src2_c[WORD_W-1:0]);
         end else begin
            src1_c = {{(XLEN-WORD_W){src1_c[WORD_W-1]}}, src1_c[WORD_W-1:0]};
            src2_c = {{(XLEN-WORD_W){src2_c[WORD_W-1]}}, src2_c[WORD_W-1:0]};
         end
      end
      in_entry_c.src1          = src1_c;
      in_entry_c.src2          = src2_c;
      in_entry_c.pc            = in_pc;
      in_entry_c.func_control  = in_func_control;
      in_entry_c.inner_control = in_inner_control;
      in_entry_c.word_op       = in_word_op;
      in_entry_c.rd            = in_rd;
      in_entry_c.rd_wen        = in_rd_wen;
   end

   // Skid-buffer next state; main is always the older entry.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid) begin
         if (in_fire_c) begin
            main_d       = in_entry_c;
            main_valid_d = 1'b1;
         end
      end else if (out_fire_c) begin
         if (in_fire_c) begin
            if (skid_valid) begin
               main_d = skid_q;
               skid_d = in_entry_c;
            end else begin
               main_d = in_entry_c;
            end
         end else begin
            if (skid_valid) begin
               main_d = skid_q;
            end
            main_valid_d = skid_valid;
            skid_valid_d = 1'b0;
         end
      end else if (in_fire_c) begin
         skid_d       = in_entry_c;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         in_ready   <= ~skid_valid_d;
      end
   end

   assign out_valid         = main_valid;
   assign out_src1          = main_q.src1;
   assign out_src2          = main_q.src2;
   assign out_func_control  = main_q.func_control;
   assign out_inner_control = main_q.inner_control;
   assign out_word_op       = main_q.word_op;
   assign out_pc            = main_q.pc;
   assign out_rd            = main_q.rd;
   assign out_rd_wen        = main_q.rd_wen;

`ifdef EXU_OPERAND_STALL_CNT_EN
   // Saturating count of cycles the ALU side held off a valid op; flush does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
